// File: rtl/fw_ip2_core.sv
// fw_ip2_core: static config regs, programmable bunch-crossing clocks, trigger and SW readback.
// Optional FW_IP2_DELAY_CLAMP_EN limits the bxclk delay to half a period.
module fw_ip2_core #(
  parameter logic [7:0] VERSION = 8'h02
) (
  input  logic        fw_pl_clk1,
  input  logic        fw_rst,
  input  logic        fw_dev_id_enable,
  input  logic        fw_op_code_w_reset,
  input  logic        fw_op_code_w_cfg_static_0,
  input  logic        fw_op_code_r_cfg_static_0,
  input  logic        fw_op_code_w_cfg_array_0,
  input  logic        fw_op_code_r_cfg_array_0,
  input  logic        fw_op_code_w_cfg_array_1,
  input  logic        fw_op_code_r_cfg_array_1,
  input  logic        fw_op_code_r_data_array_0,
  input  logic        fw_op_code_r_data_array_1,
  input  logic        fw_op_code_r_status,
  input  logic        fw_op_code_w_execute,
  input  logic [23:0] sw_write24_0,
  output logic [31:0] fw_read_data32,
  output logic [31:0] fw_read_status32,
  output logic        fw_super_pixel_sel,
  output logic        fw_config_clk,
  output logic        fw_reset_not,
  output logic        fw_config_in,
  output logic        fw_config_load,
  output logic        fw_bxclk_ana,
  output logic        fw_bxclk,
  output logic        fw_vin_test_trig_out,
  output logic        fw_scan_in,
  output logic        fw_scan_load,
  input  logic        fw_config_out,
  input  logic        fw_scan_out,
  input  logic        fw_dnn_output_0,
  input  logic        fw_dnn_output_1,
  input  logic        fw_dn_event_toggle
);
  typedef enum logic [1:0] {T_IDLE, T_ARMED, T_FIRE} trig_t;
  logic [12:0] r_cfg_s;
  logic [23:0] r_cfg_a0, r_cfg_a1;
  logic [5:0]  r_cnt, r_tcnt;
  logic        r_ana, r_bx, r_sps, r_reset_not, r_exe_d;
  logic [4:0]  r_sync1, r_sync2;
  logic [31:0] r_rd;
  trig_t       r_tstate, w_tnext;
  logic        w_wr_s, w_rst_op, w_run, w_gt, w_clamp, w_exe, w_rise, w_fire;
  logic        w_ana_raw, w_bx_raw, w_unused;
  logic [5:0]  w_p, w_h, w_deff;
  logic [4:0]  w_d;
  logic [6:0]  w_sum, w_dcnt;
  logic [31:0] w_rd;
  assign w_wr_s   = fw_dev_id_enable & fw_op_code_w_cfg_static_0;
  assign w_rst_op = fw_dev_id_enable & fw_op_code_w_reset;
  assign w_p      = r_cfg_s[5:0];
  assign w_d      = r_cfg_s[10:6];
  assign w_h      = {1'b0, w_p[5:1]};
  assign w_run    = fw_dev_id_enable & (w_p >= 6'd2);
  assign w_gt     = {1'b0, w_d} > w_h;
  assign w_unused = fw_op_code_r_status;
  always_ff @(posedge fw_pl_clk1 or posedge fw_rst)
    if (fw_rst) begin
      r_cfg_s  <= '0;
      r_cfg_a0 <= '0;
      r_cfg_a1 <= '0;
    end else if (w_rst_op) begin
      r_cfg_s  <= '0;
      r_cfg_a0 <= '0;
      r_cfg_a1 <= '0;
    end else begin
      if (w_wr_s) r_cfg_s <= sw_write24_0[12:0];
      if (fw_dev_id_enable & fw_op_code_w_cfg_array_0) r_cfg_a0 <= sw_write24_0;
      if (fw_dev_id_enable & fw_op_code_w_cfg_array_1) r_cfg_a1 <= sw_write24_0;
    end
`ifdef FW_IP2_DELAY_CLAMP_EN
  assign w_clamp = w_run & w_gt;
  assign w_deff  = w_gt ? w_h : {1'b0, w_d};
`else
  assign w_clamp = 1'b0;
  assign w_deff  = (w_p < 6'd2) ? 6'd0 : ({1'b0, w_d} % w_p);
`endif
  // dcnt = (cnt - D) mod P, kept non-negative by adding P first
  assign w_sum     = {1'b0, r_cnt} + {1'b0, w_p} - {1'b0, w_deff};
  assign w_dcnt    = (w_sum >= {1'b0, w_p}) ? w_sum - {1'b0, w_p} : w_sum;
  assign w_ana_raw = r_cnt < w_h;
  assign w_bx_raw  = (w_dcnt < {1'b0, w_h}) ^ r_cfg_s[11];
  always_ff @(posedge fw_pl_clk1 or posedge fw_rst)
    if (fw_rst) begin
      r_cnt       <= '0;
      r_ana       <= 1'b0;
      r_bx        <= 1'b0;
      r_sps       <= 1'b0;
      r_reset_not <= 1'b0;
    end else begin
      r_cnt       <= (!w_run || w_wr_s || r_cnt >= w_p - 6'd1) ? 6'd0 : r_cnt + 6'd1;
      r_ana       <= w_run & w_ana_raw;
      r_bx        <= w_run & w_bx_raw;
      r_sps       <= r_cfg_s[12];
      r_reset_not <= ~w_rst_op;
    end
  assign w_exe  = fw_dev_id_enable & fw_op_code_w_execute;
  assign w_rise = w_exe & ~r_exe_d;
  assign w_fire = w_run & (r_cnt == 6'd0);
  always_comb begin
    w_tnext = r_tstate;
    case (r_tstate)
      T_IDLE:  w_tnext = w_rise ? T_ARMED : T_IDLE;
      T_ARMED: w_tnext = w_fire ? T_FIRE : T_ARMED;
      T_FIRE:  w_tnext = (r_tcnt == 6'd0) ? T_IDLE : T_FIRE;
      default: w_tnext = T_IDLE;
    endcase
  end
  always_ff @(posedge fw_pl_clk1 or posedge fw_rst)
    if (fw_rst) begin
      r_tstate <= T_IDLE;
      r_tcnt   <= '0;
      r_exe_d  <= 1'b0;
    end else begin
      r_tstate <= w_tnext;
      r_exe_d  <= w_exe;
      if (r_tstate == T_ARMED && w_fire) r_tcnt <= w_p - 6'd1;
      else if (r_tstate == T_FIRE && r_tcnt != 6'd0) r_tcnt <= r_tcnt - 6'd1;
    end
  always_ff @(posedge fw_pl_clk1 or posedge fw_rst)
    if (fw_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {fw_dn_event_toggle, fw_scan_out, fw_config_out, fw_dnn_output_1, fw_dnn_output_0};
      r_sync2 <= r_sync1;
    end
  always_comb
    w_rd = !fw_dev_id_enable             ? 32'd0 :
           fw_op_code_r_cfg_static_0     ? {19'd0, r_cfg_s} :
           fw_op_code_r_cfg_array_0      ? {8'd0, r_cfg_a0} :
           fw_op_code_r_cfg_array_1      ? {8'd0, r_cfg_a1} :
           (fw_op_code_r_data_array_0 | fw_op_code_r_data_array_1) ? {27'd0, r_sync2} : 32'd0;
  always_ff @(posedge fw_pl_clk1 or posedge fw_rst)
    if (fw_rst) r_rd <= '0;
    else r_rd <= w_rd;
  assign fw_read_data32       = r_rd;
  assign fw_read_status32     = {VERSION, 20'd0, w_clamp, r_tstate == T_ARMED, r_tstate == T_FIRE, w_run};
  assign fw_super_pixel_sel   = r_sps;
  assign fw_reset_not         = r_reset_not;
  assign fw_bxclk_ana         = r_ana;
  assign fw_bxclk             = r_bx;
  assign fw_vin_test_trig_out = r_tstate == T_FIRE;
  assign fw_config_clk        = 1'b0;
  assign fw_config_in         = 1'b0;
  assign fw_config_load       = 1'b0;
  assign fw_scan_in           = 1'b0;
  assign fw_scan_load         = 1'b0;
endmodule

// File: tb/tb_fw_ip2_core.sv
// tb_fw_ip2_core: scoreboard bench measuring clock periods/delays, trigger width and readback.
`timescale 1ns/1ps
module tb_fw_ip2_core;
  logic clk = 0, rst = 1, en = 0, w_reset = 0, w_exec = 0, w_st = 0, w_a0 = 0, w_a1 = 0, r_status = 0;
  logic [4:0]  rdv = '0;
  logic [4:0]  dut_in = '0;
  logic [23:0] sw = '0;
  logic [31:0] rd_data, status;
  logic sps, cfg_clk, reset_not, cfg_in, cfg_load, ana, bx, trig, scan_in, scan_load;
  int n_vec = 0, n_err = 0;
  int per_q[$], dly_q[$], exp_q[$];
  always #1.25 clk = ~clk;
  fw_ip2_core dut (
    .fw_pl_clk1(clk), .fw_rst(rst), .fw_dev_id_enable(en),
    .fw_op_code_w_reset(w_reset), .fw_op_code_w_cfg_static_0(w_st), .fw_op_code_r_cfg_static_0(rdv[0]),
    .fw_op_code_w_cfg_array_0(w_a0), .fw_op_code_r_cfg_array_0(rdv[1]),
    .fw_op_code_w_cfg_array_1(w_a1), .fw_op_code_r_cfg_array_1(rdv[2]),
    .fw_op_code_r_data_array_0(rdv[3]), .fw_op_code_r_data_array_1(rdv[4]),
    .fw_op_code_r_status(r_status), .fw_op_code_w_execute(w_exec), .sw_write24_0(sw),
    .fw_read_data32(rd_data), .fw_read_status32(status),
    .fw_super_pixel_sel(sps), .fw_config_clk(cfg_clk), .fw_reset_not(reset_not),
    .fw_config_in(cfg_in), .fw_config_load(cfg_load), .fw_bxclk_ana(ana), .fw_bxclk(bx),
    .fw_vin_test_trig_out(trig), .fw_scan_in(scan_in), .fw_scan_load(scan_load),
    .fw_config_out(dut_in[2]), .fw_scan_out(dut_in[3]), .fw_dnn_output_0(dut_in[0]),
    .fw_dnn_output_1(dut_in[1]), .fw_dn_event_toggle(dut_in[4])
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic logic [23:0] cfg(input int p, input int d, input bit s, input bit x);
    logic [5:0] pp;
    logic [4:0] dd;
    pp = p[5:0];
    dd = d[4:0];
    return {11'd0, x, s, dd, pp};
  endfunction
  function automatic int ps_since(input realtime t);
    return int'(($realtime - t) * 1000.0);
  endfunction
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input int which, input logic [23:0] d);
    @(negedge clk);
    sw = d;
    w_st = (which == 0);
    w_a0 = (which == 1);
    w_a1 = (which == 2);
    tick(4);
    {w_st, w_a0, w_a1} = '0;
  endtask
  task automatic rd(input string tag, input logic [4:0] sel, input logic [31:0] e);
    rdv = sel;
    exp_q.push_back(e);
    @(negedge clk);
    chk(tag, rd_data, exp_q.pop_front());
    rdv = '0;
    exp_q.push_back(32'd0);
    @(negedge clk);
    chk({tag, "_idle"}, rd_data, exp_q.pop_front());
  endtask
  task automatic meas(input int p, input int d, input bit s, input int n);
    int nr = 0, de;
    bit pend = 0;
    realtime tl = 0;
    logic pa, pb;
`ifdef FW_IP2_DELAY_CLAMP_EN
    de = (d > p / 2) ? p / 2 : d;
`else
    de = d % p;
`endif
    for (int i = 0; i < n; i++) begin
      per_q.push_back(p * 2500);
      dly_q.push_back(de * 2500);
    end
    pa = ana;
    pb = bx;
    for (int c = 0; c < (n + 3) * p + 20 && (per_q.size() > 0 || dly_q.size() > 0); c++) begin
      @(negedge clk);
      if (ana && !pa) begin
        if (nr > 0 && per_q.size() > 0) chk("period", ps_since(tl), per_q.pop_front());
        tl = $realtime;
        nr++;
        pend = 1;
      end
      if (pend && (s ? (!bx && pb) : (bx && !pb))) begin
        if (dly_q.size() > 0) chk("delay", ps_since(tl), dly_q.pop_front());
        pend = 0;
      end
      pa = ana;
      pb = bx;
    end
    if (per_q.size() + dly_q.size() > 0) chk("clk_timeout", per_q.size() + dly_q.size(), 0);
    per_q.delete();
    dly_q.delete();
  endtask
  task automatic trig_meas(input int p);
    int w = 0;
    logic pa;
    bit seen = 0;
    exp_q.push_back(p * 2500);
    pa = ana;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (trig) begin
        seen = 1;
        chk("trig_align", {30'd0, pa, ana}, 32'd1);
        chk("st_trig", status[1], 1);
      end
      pa = ana;
    end
    if (!seen) chk("trig_timeout", 0, 1);
    for (int c = 0; c < 200 && seen && trig; c++) begin
      w++;
      @(negedge clk);
    end
    chk("trig_width", w * 2500, exp_q.pop_front());
  endtask
  initial begin
    tick(3);
    chk("rst_reset_not", reset_not, 0);
    @(negedge clk) rst = 0;
    @(negedge clk);
    chk("rst_clks", {ana, bx, trig, sps}, 0);
    chk("rst_reset_not_rel", reset_not, 1);
    chk("rst_rd", rd_data, 0);
    chk("rst_status", status, 32'h0200_0000);
    chk("rst_reserved", {cfg_clk, cfg_in, cfg_load, scan_in, scan_load}, 0);
    en = 1;
    wr(0, cfg(10, 2, 0, 0));
    chk("st_run", status[0], 1);
    meas(10, 2, 0, 3);
    wr(0, cfg(17, 4, 1, 0));
    meas(17, 4, 1, 3);
    wr(0, cfg(12, 0, 0, 0));
    meas(12, 0, 0, 2);
    wr(0, cfg(12, 0, 1, 0));
    meas(12, 0, 1, 2);
    wr(0, cfg(10, 13, 0, 0));
    meas(10, 13, 0, 2);
    repeat (50) begin
      int p, d;
      bit s;
      p = $urandom_range(40, 10);
      d = $urandom_range(p / 2, 0);
      s = 1'($urandom_range(1, 0));
      wr(0, cfg(p, d, s, 0));
      meas(p, d, s, 1);
    end
    wr(0, cfg(10, 2, 0, 1));
    tick(2);
    chk("sps", sps, 1);
    rd("rd_static", 5'b00001, 32'h0000_1000 | (2 << 6) | 10);
    en = 0;
    @(negedge clk);
    chk("dis_clks", {ana, bx}, 0);
    chk("dis_status", status[0], 0);
    tick(5);
    chk("dis_clks_hold", {ana, bx}, 0);
    en = 1;
    meas(10, 2, 0, 2);
    wr(1, 24'h001ABC);
    rd("rd_a0", 5'b00010, 32'h0000_1ABC);
    wr(2, 24'hFEDCBA);
    rd("rd_a1", 5'b00100, 32'h00FE_DCBA);
    rd("rd_prio", 5'b00111, 32'h0000_1000 | (2 << 6) | 10);
    dut_in = 5'b10110;
    tick(3);
    rd("rd_d0", 5'b01000, 32'h16);
    dut_in = 5'b01001;
    tick(3);
    rd("rd_d1", 5'b10000, 32'h09);
    en = 0;
    rd("rd_dis", 5'b00010, 32'h0);
    en = 1;
    @(negedge clk) w_reset = 1;
    @(negedge clk);
    chk("wreset_low", reset_not, 0);
    tick(3);
    w_reset = 0;
    @(negedge clk);
    chk("wreset_high", reset_not, 1);
    rd("rd_clr_static", 5'b00001, 32'h0);
    rd("rd_clr_a0", 5'b00010, 32'h0);
    @(negedge clk) w_exec = 1;
    @(negedge clk);
    chk("armed", status[2], 1);
    tick(3);
    w_exec = 0;
    tick(30);
    chk("armed_hold", {status[2], status[1], trig}, 32'h4);
    fork
      wr(0, cfg(10, 2, 0, 1));
      trig_meas(10);
    join
    chk("disarmed", status[2:1], 0);
    tick(7);
    @(negedge clk) w_exec = 1;
    fork
      begin tick(4); w_exec = 0; end
      trig_meas(10);
    join
    for (int c = 0; c < 20 && !ana; c++) @(negedge clk);
    #0.3 rst = 1;
    #0.1;
    chk("async_rst", {rd_data[0], ana, bx, reset_not, trig, sps}, 0);
    chk("async_rst_st", status, 32'h0200_0000);
    @(negedge clk) rst = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fw_ip2_core.md
Name: fw_ip2_core

Overview:
- Firmware IP #2 of the CMS pixel-28 test firmware, sitting between the common SW-to-FW decoder and the common FW-to-DUT pin mux.
- Holds a static configuration register written by SW op-code strobes.
- Generates the DUT bunch-crossing clocks fw_bxclk_ana and fw_bxclk from the 400 MHz clock, with programmable period, delay and polarity.
- Provides readback and status words to SW.

Parameters:
- VERSION, 8'h02, reported in fw_read_status32[31:24].

Ports:
- Clock and reset are one clock and an asynchronous, active-high reset, as decided for this block.
- fw_pl_clk1  in  1  sole clock, 400 MHz (2.5 ns tick); all logic on its rising edge.
- fw_rst  in  1  asynchronous, active-high reset.
- fw_dev_id_enable  in  1  block selected; gates all op-codes and clock generation.
- fw_op_code_w_reset, fw_op_code_w_cfg_static_0, fw_op_code_r_cfg_static_0, fw_op_code_w_cfg_array_0, fw_op_code_r_cfg_array_0, fw_op_code_w_cfg_array_1, fw_op_code_r_cfg_array_1, fw_op_code_r_data_array_0, fw_op_code_r_data_array_1, fw_op_code_r_status, fw_op_code_w_execute  in  1 each  level op-code strobes (typically 4 ticks wide).
- sw_write24_0  in  24  write data.
- fw_read_data32  out  32  readback data.
- fw_read_status32  out  32  status word.
- fw_super_pixel_sel, fw_config_clk, fw_reset_not, fw_config_in, fw_config_load, fw_bxclk_ana, fw_bxclk, fw_vin_test_trig_out, fw_scan_in, fw_scan_load  out  1 each  DUT-side drives.
- fw_config_out, fw_scan_out, fw_dnn_output_0, fw_dnn_output_1, fw_dn_event_toggle  in  1 each  DUT-side returns.

Behaviour:
- Write gating: a write occurs on every tick where fw_dev_id_enable=1 and the write strobe is 1. Repeated writes of the same data are idempotent.
- cfg_static_0[12:0] <= sw_write24_0[12:0] when written:
  - P = [5:0], period in ticks.
  - D = [10:6], delay in ticks.
  - S = [11], delay sign.
  - [12] = super_pix_sel.
- cfg_array_0 and cfg_array_1 are 24-bit registers, written from sw_write24_0.
- fw_op_code_w_reset clears all three config registers.
- Reset values: all registers and outputs 0, except fw_reset_not, which is 0 during fw_rst and goes to 1 on the first tick after release.
- fw_reset_not is 0 while the gated w_reset strobe is high, otherwise 1.
- Phase counter cnt, 0..P-1:
  - Held at 0 when fw_dev_id_enable=0, P<2, or on any cycle writing cfg_static_0 (phase restart).
  - Otherwise increments and wraps from P-1 to 0.
- Clock waveforms (H = floor(P/2)):
  - ana_raw = (cnt < H).
  - dcnt = (cnt - D) mod P.
  - bx_raw = (dcnt < H) XOR S.
- Both clocks are registered (one tick latency) and glitch-free.
- When disabled or P<2, fw_bxclk_ana=0 and fw_bxclk=0 regardless of S.
- Required timing:
  - Consecutive rising edges of either clock are exactly P*2.5 ns apart.
  - S=0: bxclk rising edge is D ticks after the ana rising edge.
  - S=1: bxclk falling edge is D ticks after the ana rising edge.
  - D=0: the edges coincide on the same tick (S=1 gives the inverted clock).
- Without the optional feature, D >= P is reduced mod P.
- fw_super_pixel_sel = cfg_static_0[12], registered.
- fw_vin_test_trig_out:
  - A rising edge of the gated w_execute strobe arms a trigger.
  - At the next cnt==0 the output goes high for exactly P ticks, then low.
  - Re-arming while high is ignored.
  - If the clock is disabled, the trigger stays armed.
- fw_config_clk, fw_config_in, fw_config_load, fw_scan_in and fw_scan_load are driven 0 (reserved for the array shift engine).
- DUT inputs pass through 2-flop synchronizers before use.
- fw_read_data32 is registered, 1 tick latency, and 0 when no read strobe is active or the block is disabled:
  - r_cfg_static_0 returns {19'b0, cfg_static_0}.
  - r_cfg_array_0 and r_cfg_array_1 return {8'b0, array}.
  - r_data_array_0 and r_data_array_1 return {27'b0, dn_event_toggle, scan_out, config_out, dnn_output_1, dnn_output_0}.
  - Simultaneous read strobes resolve in the priority order just listed.
- fw_read_status32 is continuously valid, independent of r_status:
  - [31:24] = VERSION.
  - [2] = trigger armed.
  - [1] = trig_out high.
  - [0] = clocks running (enable & P>=2).
  - All other bits 0.
- fw_rst asserted mid-operation immediately forces all outputs to their reset values.

Optional Feature:
- Macro FW_IP2_DELAY_CLAMP_EN.
- Defined: the effective D = min(D, H), so bxclk never lags by more than half a period; status[3] = 1 when clamping is active.
- Undefined: D is used mod P and status[3] = 0.

Test Plan:
- Reset: hold fw_rst 1..5 axi periods, release -> both clocks 0, fw_reset_not=1, read_data=0, status[31:24]=8'h02.
- Write P=10, D=2, S=0, enable -> ana rising edges 25.0 ns apart; bxclk rising edge 5.0 ns after each ana rising edge.
- Write P=17, D=4, S=1 -> period 42.5 ns on both clocks; bxclk falling edge 10.0 ns after the ana rising edge.
- D=0: S=0 gives bxclk identical to ana; S=1 gives bxclk = ~ana; 50 random P in 10..40, D in 0..P/2 -> no period or delay errors.
- Deassert fw_dev_id_enable -> both clocks 0 within 1 tick, status[0]=0; re-enable -> clocks resume with the same settings.
- Write 24'h1ABC to cfg_array_0, then r_cfg_array_0 -> read_data32=32'h00001ABC one tick later. w_execute with P=10 -> trig_out high for 25.0 ns starting at the ana rising edge.
